system_ecc_scrub_ctrl: RTL
==========================

SYSTEM_ECC_SCRUB_CTRL -- requirements
Module: system_ecc_scrub_ctrl

Interface
REQ-001 SHALL have parameters: ADDR_W, default 6, memory address width (depth 2^ADDR_W); SCRUB_INTERVAL, default 1024, idle cycles between scrub ops; STARVE_MAX, default 4, consecutive host grants allowed while a scrub is pending.
REQ-002 SHALL have ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- scrub_en  in  1  background scrub enable
- host_req  in  1  host request valid
- host_we  in  1  1=write, 0=read
- host_addr  in  ADDR_W  host address
- host_wdata  in  8  host write data
- host_ready  out  1  request accepted when host_req&&host_ready
- host_rvalid  out  1  one-cycle read-data strobe
- host_rdata  out  8  corrected read data
- host_err_corr  out  1  qualifies host_rvalid: single error corrected
- host_err_uncorr  out  1  qualifies host_rvalid: uncorrectable error
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  13  codeword to memory
- mem_rdata  in  13  codeword from memory, valid 1 cycle after read strobe
- irq_clr  in  1  clears irq_uncorr
- irq_uncorr  out  1  sticky uncorrectable-error flag
- scrub_busy  out  1  high in scrub states
- stat_corr_cnt  out  16  corrected-error count, saturating
- stat_uncorr_cnt  out  16  uncorrectable-error count, saturating

Function
REQ-003 Codeword SHALL be 13 bits: Hamming parity at bits 0,1,3,7; data[7:0] at bits 2,4,5,6,8,9,10,11; bit 12 = XOR of bits 11:0 (overall even parity).
REQ-004 Parity bit at index 2^i-1 SHALL equal XOR of bits j (j not equal 2^i-1, j<12) where (j+1) has bit i set.
REQ-005 Decode: s = XOR of (j+1) over set bits j<12; p = XOR of all 13 bits. p=0,s=0 clean; p=1,s=0 bit 12 flipped (correctable); p=1,1<=s<=12 flip bit s-1 (correctable); p=0,s!=0 or p=1,s>12 uncorrectable, data passed raw.
REQ-006 FSM states: IDLE, H_WR, H_RD, H_CHK, H_WB, S_RD, S_CHK, S_WB.
REQ-007 host_ready SHALL be 1 only in IDLE, and 0 there when scrub is pending and starvation count = STARVE_MAX.
REQ-008 Host write accepted in cycle T -> H_WR at T+1 drives mem_en=1, mem_we=1, encoded codeword -> IDLE.
REQ-009 Host read accepted at T -> H_RD at T+1 (mem_en=1, mem_we=0) -> H_CHK at T+2 samples mem_rdata -> host_rvalid=1 with rdata/flags at T+3.
REQ-010 H_CHK correctable -> H_WB writes corrected codeword at T+3, then IDLE; clean or uncorrectable -> IDLE (no writeback).
REQ-011 Scrub timer SHALL count cycles while scrub_en and no scrub pending; at SCRUB_INTERVAL-1 set scrub pending and reset timer.
REQ-012 In IDLE, pending scrub SHALL win when host_req=0 or starvation count = STARVE_MAX; otherwise host wins and starvation count increments; count clears on scrub grant.
REQ-013 Scrub: S_RD read at scrub_addr -> S_CHK decode -> S_WB writeback only if correctable -> IDLE; scrub_addr increments after S_CHK, wraps 2^ADDR_W-1 -> 0.
REQ-014 Each correctable/uncorrectable decode (host or scrub) SHALL increment its counter by 1, holding at 16'hFFFF.
REQ-015 irq_uncorr SHALL set on any uncorrectable decode; irq_clr clears; simultaneous set and clr -> set wins.
REQ-016 scrub_en deasserted mid-scrub: current op completes; timer and pending cleared; scrub_addr retained.
REQ-017 mem_en SHALL be 0 in IDLE, H_CHK, S_CHK.

Reset
REQ-018 rst_n low SHALL force: state IDLE, all outputs 0 (host_ready 0 during reset, 1 the first cycle after), timer, pending, starvation count, scrub_addr, counters, irq_uncorr cleared; in-flight op is abandoned.

Structure
REQ-019 Shared package SHALL hold: codeword width 13, data width 8, parity-position and data-position tables, FSM state enum, error-class enum {CLEAN, CORR, UNCORR}.
REQ-020 Encode/decode SHALL live in one combinational sub-module secded13_codec (data->codeword; codeword->corrected data, class), used for host and scrub paths.

Verification
REQ-021 Write addr 5 data 8'hA5, read addr 5 -> host_rvalid at T+3, rdata A5, both flags 0.
REQ-022 Memory model flips bit 4 at addr 5, host read -> rdata A5, err_corr=1, H_WB writes clean codeword, stat_corr_cnt=1.
REQ-023 Flip bits 2 and 9 -> err_uncorr=1, irq_uncorr=1, no writeback; irq_clr with new uncorr same cycle -> irq stays 1.
REQ-024 SCRUB_INTERVAL=8, host_req held continuously -> after 4 host grants host_ready=0, S_RD issued, scrub_busy=1.
REQ-025 Scrub across full depth with bit 12 flipped at addr 63 -> corrected writeback at 63, next scrub at addr 0.
REQ-026 rst_n asserted in H_CHK -> no host_rvalid, all outputs 0, counters 0.

Source files
------------

// File: rtl/system_ecc_scrub_ctrl_pkg.sv
// Shared definitions for the ECC scrub controller: SECDED(13,8) layout,
// FSM state encoding and decode error classes.
package system_ecc_scrub_ctrl_pkg;

  localparam int unsigned CW_W   = 13;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned PAR_N  = 4;

  // Hamming parity bits sit at 2^i-1; data fills the remaining low positions.
  localparam int unsigned PAR_POS  [PAR_N]  = '{0, 1, 3, 7};
  localparam int unsigned DATA_POS [DATA_W] = '{2, 4, 5, 6, 8, 9, 10, 11};

  typedef enum logic [2:0] {
    IDLE, H_WR, H_RD, H_CHK, H_WB, S_RD, S_CHK, S_WB
  } state_t;

  typedef enum logic [1:0] {
    CLEAN, CORR, UNCORR
  } err_t;

endpackage

// File: rtl/system_ecc_scrub_ctrl_codec.sv
// Combinational SECDED(13,8) encoder and decoder/corrector.
module secded13_codec
  import system_ecc_scrub_ctrl_pkg::*;
(
  input  logic [DATA_W-1:0] i_enc_data,
  output logic [CW_W-1:0]   o_enc_cw,
  input  logic [CW_W-1:0]   i_dec_cw,
  output logic [DATA_W-1:0] o_dec_data,
  output logic [1:0]        o_dec_err
);

  logic [CW_W-1:0] w_cw;
  logic            w_par;
  logic [3:0]      w_syn;
  logic            w_par_all;
  logic [CW_W-1:0] w_fix;

  // Encode: place data, compute each Hamming parity, then overall parity.
  always_comb begin
    w_cw  = '0;
    w_par = 1'b0;
    for (int unsigned i = 0; i < DATA_W; i++) w_cw[DATA_POS[i]] = i_enc_data[i];
    for (int unsigned i = 0; i < PAR_N; i++) begin
      w_par = 1'b0;
      for (int unsigned j = 0; j < CW_W - 1; j++)
        if ((j != PAR_POS[i]) && ((((j + 1) >> i) & 32'd1) != 32'd0)) w_par = w_par ^ w_cw[j];
      w_cw[PAR_POS[i]] = w_par;
    end
    w_cw[CW_W-1] = ^w_cw[CW_W-2:0];
    o_enc_cw     = w_cw;
  end

  // Decode: syndrome + overall parity select clean / single-fix / uncorrectable.
  always_comb begin
    w_syn = '0;
    for (int unsigned j = 0; j < CW_W - 1; j++)
      if (i_dec_cw[j]) w_syn = w_syn ^ 4'(j + 1);
    w_par_all  = ^i_dec_cw;
    w_fix      = i_dec_cw;
    o_dec_err  = CLEAN;
    o_dec_data = '0;
    if (w_par_all) begin
      if (w_syn == 4'd0) begin
        w_fix[CW_W-1] = ~w_fix[CW_W-1];
        o_dec_err     = CORR;
      end else if (w_syn <= 4'd12) begin
        w_fix[w_syn - 4'd1] = ~w_fix[w_syn - 4'd1];
        o_dec_err           = CORR;
      end else begin
        o_dec_err = UNCORR;
      end
    end else if (w_syn != 4'd0) begin
      o_dec_err = UNCORR;
    end
    for (int unsigned i = 0; i < DATA_W; i++) o_dec_data[i] = w_fix[DATA_POS[i]];
  end

endmodule

// File: rtl/system_ecc_scrub_ctrl.sv
// ECC memory front-end: host read/write with SECDED correction and writeback,
// plus a periodic background scrubber with bounded host starvation.
module system_ecc_scrub_ctrl
  import system_ecc_scrub_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W         = 6,
  parameter int unsigned SCRUB_INTERVAL = 1024,
  parameter int unsigned STARVE_MAX     = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              scrub_en,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [7:0]        host_wdata,
  output logic              host_ready,
  output logic              host_rvalid,
  output logic [7:0]        host_rdata,
  output logic              host_err_corr,
  output logic              host_err_uncorr,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [12:0]       mem_wdata,
  input  logic [12:0]       mem_rdata,
  input  logic              irq_clr,
  output logic              irq_uncorr,
  output logic              scrub_busy,
  output logic [15:0]       stat_corr_cnt,
  output logic [15:0]       stat_uncorr_cnt
);

  state_t              r_state;
  logic                r_live;
  logic [31:0]         r_timer;
  logic [31:0]         r_starve;
  logic                r_pend;
  logic [ADDR_W-1:0]   r_scrub_addr;
  logic                r_mem_en, r_mem_we, r_rvalid, r_err_corr, r_err_uncorr, r_busy, r_irq;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [12:0]         r_mem_wdata;
  logic [7:0]          r_rdata;
  logic [15:0]         r_corr_cnt, r_uncorr_cnt;

  logic [7:0]  w_enc_data, w_dec_data;
  logic [12:0] w_enc_cw;
  logic [1:0]  w_dec_err;
  logic        w_starved, w_scrub_win, w_host_acc, w_chk;

  // Encoder serves host writes from IDLE and corrected writebacks from the CHK states.
  assign w_enc_data  = (r_state == IDLE) ? host_wdata : w_dec_data;
  assign w_starved   = (r_starve == STARVE_MAX);
  assign host_ready  = r_live && (r_state == IDLE) && !(r_pend && w_starved);
  assign w_scrub_win = (r_state == IDLE) && r_pend && scrub_en && (!host_req || w_starved);
  assign w_host_acc  = host_req && host_ready && !w_scrub_win;
  assign w_chk       = (r_state == H_CHK) || (r_state == S_CHK);

  secded13_codec u_codec (
    .i_enc_data (w_enc_data),
    .o_enc_cw   (w_enc_cw),
    .i_dec_cw   (mem_rdata),
    .o_dec_data (w_dec_data),
    .o_dec_err  (w_dec_err)
  );

  // Scrub interval timer, pending flag and host starvation count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_live   <= 1'b0;
      r_timer  <= '0;
      r_pend   <= 1'b0;
      r_starve <= '0;
    end else begin
      r_live <= 1'b1;
      if (!scrub_en) begin
        r_timer  <= '0;
        r_pend   <= 1'b0;
        r_starve <= '0;
      end else if (w_scrub_win) begin
        r_pend   <= 1'b0;
        r_starve <= '0;
      end else begin
        if (!r_pend) begin
          if (r_timer == SCRUB_INTERVAL - 1) begin
            r_pend  <= 1'b1;
            r_timer <= '0;
          end else begin
            r_timer <= r_timer + 32'd1;
          end
        end
        if (w_host_acc && r_pend) r_starve <= r_starve + 32'd1;
      end
    end
  end

  // Main FSM with registered memory/host outputs and scrub address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_mem_en     <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_rvalid     <= 1'b0;
      r_rdata      <= '0;
      r_err_corr   <= 1'b0;
      r_err_uncorr <= 1'b0;
      r_busy       <= 1'b0;
      r_scrub_addr <= '0;
    end else begin
      r_mem_en     <= 1'b0;
      r_mem_we     <= 1'b0;
      r_rvalid     <= 1'b0;
      r_err_corr   <= 1'b0;
      r_err_uncorr <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_scrub_win) begin
            r_state    <= S_RD;
            r_mem_en   <= 1'b1;
            r_mem_addr <= r_scrub_addr;
            r_busy     <= 1'b1;
          end else if (w_host_acc) begin
            r_state    <= host_we ? H_WR : H_RD;
            r_mem_en   <= 1'b1;
            r_mem_we   <= host_we;
            r_mem_addr <= host_addr;
            if (host_we) r_mem_wdata <= w_enc_cw;
          end
        end
        H_WR: r_state <= IDLE;
        H_RD: r_state <= H_CHK;
        H_CHK: begin
          r_rvalid     <= 1'b1;
          r_rdata      <= w_dec_data;
          r_err_corr   <= (w_dec_err == CORR);
          r_err_uncorr <= (w_dec_err == UNCORR);
          if (w_dec_err == CORR) begin
            r_state     <= H_WB;
            r_mem_en    <= 1'b1;
            r_mem_we    <= 1'b1;
            r_mem_wdata <= w_enc_cw;
          end else begin
            r_state <= IDLE;
          end
        end
        H_WB: r_state <= IDLE;
        S_RD: r_state <= S_CHK;
        S_CHK: begin
          r_scrub_addr <= r_scrub_addr + 1'b1;
          if (w_dec_err == CORR) begin
            r_state     <= S_WB;
            r_mem_en    <= 1'b1;
            r_mem_we    <= 1'b1;
            r_mem_wdata <= w_enc_cw;
          end else begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        S_WB: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Saturating error statistics and sticky uncorrectable interrupt (set beats clear).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_corr_cnt   <= '0;
      r_uncorr_cnt <= '0;
      r_irq        <= 1'b0;
    end else begin
      if (w_chk && (w_dec_err == CORR) && (r_corr_cnt != 16'hFFFF))
        r_corr_cnt <= r_corr_cnt + 16'd1;
      if (w_chk && (w_dec_err == UNCORR) && (r_uncorr_cnt != 16'hFFFF))
        r_uncorr_cnt <= r_uncorr_cnt + 16'd1;
      if (w_chk && (w_dec_err == UNCORR)) r_irq <= 1'b1;
      else if (irq_clr)                   r_irq <= 1'b0;
    end
  end

  assign mem_en          = r_mem_en;
  assign mem_we          = r_mem_we;
  assign mem_addr        = r_mem_addr;
  assign mem_wdata       = r_mem_wdata;
  assign host_rvalid     = r_rvalid;
  assign host_rdata      = r_rdata;
  assign host_err_corr   = r_err_corr;
  assign host_err_uncorr = r_err_uncorr;
  assign scrub_busy      = r_busy;
  assign irq_uncorr      = r_irq;
  assign stat_corr_cnt   = r_corr_cnt;
  assign stat_uncorr_cnt = r_uncorr_cnt;

endmodule
